// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that lets N producers take turns writing one shared W-bit register.
// An owner writes every cycle it holds the grant and loses ownership after MAX_HOLD writes.
module shared_reg_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 4,
  localparam int IW      = (N > 1) ? $clog2(N) : 1,
  localparam int HW      = $clog2(MAX_HOLD) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  d_in,
  output logic [N-1:0]    grant,
  output logic [IW-1:0]   owner,
  output logic            busy,
  output logic [W-1:0]    q,
  output logic            forced,
  output logic [0:0]      state_dbg,
  output logic [IW-1:0]   ptr_dbg
);

  // Handshake: req is a level; a requester owns the register from the cycle
  // grant goes high until the cycle grant drops, and writes on every such edge.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]    state;
  logic [IW-1:0] ptr;
  logic [HW-1:0] hold_cnt;

  logic [IW-1:0] winner;
  logic [N-1:0]  win_onehot;
  logic          found;
  logic [IW-1:0] next_ptr;
  logic          owner_req;
  logic          hold_expired;

  // Search starts at ptr and wraps, so the last owner has the lowest priority.
  always_comb begin
    winner     = ptr;
    found      = 1'b0;
    win_onehot = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && req[(int'(ptr) + k) % N]) begin
        winner = IW'((int'(ptr) + k) % N);
        found  = 1'b1;
      end
    end
    win_onehot[winner] = 1'b1;
  end

  always_comb begin
    next_ptr     = (int'(owner) == N - 1) ? '0 : owner + IW'(1);
    owner_req    = req[owner];
    hold_expired = (hold_cnt == HW'(MAX_HOLD - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      owner    <= '0;
      busy     <= 1'b0;
      q        <= '0;
      forced   <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          forced <= 1'b0;
          if (found) begin
            grant    <= win_onehot;
            owner    <= winner;
            busy     <= 1'b1;
            q        <= d_in[int'(winner)*W +: W];
            hold_cnt <= '0;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (!owner_req || hold_expired) begin
            grant  <= '0;
            busy   <= 1'b0;
            forced <= owner_req;
            ptr    <= next_ptr;
            state  <= IDLE;
          end else begin
            q        <= d_in[int'(owner)*W +: W];
            hold_cnt <= hold_cnt + HW'(1);
            forced   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_dbg = state;
  assign ptr_dbg   = ptr;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: directed scenarios plus random traffic, each
// cycle compared against an ownership-level reference model.
module tb_shared_reg_arbiter;
  localparam int N        = 4;
  localparam int W        = 8;
  localparam int MAX_HOLD = 4;
  localparam int IW       = $clog2(N);

  logic            clk;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*W-1:0]  d_in;
  logic [N-1:0]    grant;
  logic [IW-1:0]   owner;
  logic            busy;
  logic [W-1:0]    q;
  logic            forced;
  logic [0:0]      state_dbg;
  logic [IW-1:0]   ptr_dbg;

  shared_reg_arbiter #(.N(N), .W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset), .req(req), .d_in(d_in),
    .grant(grant), .owner(owner), .busy(busy), .q(q), .forced(forced),
    .state_dbg(state_dbg), .ptr_dbg(ptr_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: who owns the register and how many writes it has made
  int         m_active;
  int         m_last;
  int         m_writes;
  int         m_ptr;
  int         m_forced;
  logic [W-1:0] m_q;

  logic [W-1:0] exp_q[$];
  logic [N-1:0] prev_grant;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] d);
    if (r) begin
      m_active = 0; m_last = 0; m_writes = 0; m_ptr = 0; m_forced = 0; m_q = '0;
    end else if (m_active == 0) begin
      m_forced = 0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (m_active == 0 && rq[idx]) begin
          m_active = 1;
          m_last   = idx;
          m_writes = 1;
          m_q      = d[idx*W +: W];
        end
      end
    end else if (!rq[m_last] || m_writes == MAX_HOLD) begin
      m_forced = rq[m_last] ? 1 : 0;
      m_active = 0;
      m_ptr    = (m_last + 1) % N;
    end else begin
      m_q      = d[m_last*W +: W];
      m_writes = m_writes + 1;
      m_forced = 0;
    end
  endtask

  task automatic check_model();
    logic [N-1:0] eg;
    eg = (m_active != 0) ? (N'(1) << m_last) : '0;
    chk("grant", 32'(grant), 32'(eg));
    chk("owner", 32'(owner), 32'(m_last));
    chk("busy", 32'(busy), 32'(m_active));
    chk("q", 32'(q), 32'(m_q));
    chk("forced", 32'(forced), 32'(m_forced));
    chk("ptr", 32'(ptr_dbg), 32'(m_ptr));
    chk("state", 32'(state_dbg), 32'(m_active));
  endtask

  // driver: apply inputs away from the edge, advance model, sample 1ns after edge
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] d);
    @(negedge clk);
    prev_grant = grant;
    reset = r;
    req   = rq;
    d_in  = d;
    @(posedge clk);
    model_edge(r, rq, d);
    #1;
    check_model();
  endtask

  initial begin
    logic [N*W-1:0] d;
    int forced_cnt;
    reset = 1'b1; req = '0; d_in = '0;
    m_active = 0; m_last = 0; m_writes = 0; m_ptr = 0; m_forced = 0; m_q = '0;
    prev_grant = '0;

    // reset with all requests high
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b1111, {N{8'h5A}});
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_q", 32'(q), 32'h0);
    end
    step(1'b0, 4'b1111, {N{8'h5A}});
    chk("first_grant", 32'(grant), 32'h1);

    // single write from requester 2
    step(1'b1, 4'b0000, '0);
    d = '0; d[2*W +: W] = 8'hA5;
    step(1'b0, 4'b0100, d);
    chk("single_grant", 32'(grant), 32'h4);
    chk("single_q", 32'(q), 32'hA5);
    step(1'b0, 4'b0000, d);
    chk("single_rel_grant", 32'(grant), 32'h0);
    chk("single_rel_busy", 32'(busy), 32'h0);
    chk("single_rel_forced", 32'(forced), 32'h0);
    chk("single_rel_ptr", 32'(ptr_dbg), 32'h3);

    // round robin with hold-limit expiry
    step(1'b1, 4'b0000, '0);
    exp_q = {8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
    forced_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      step(1'b0, 4'b1111, 32'($urandom));
      if (forced) forced_cnt++;
      if (prev_grant == '0 && grant != '0) begin
        if (exp_q.size() > 0) chk("rr_order", 32'(owner), 32'(exp_q.pop_front()));
        else chk("rr_extra_grant", 32'(owner), 32'hFFFF);
      end
    end
    chk("rr_all_seen", 32'(exp_q.size()), 32'h0);
    chk("rr_forced_cnt", 32'(forced_cnt), 32'd5);

    // streaming data from requester 1
    step(1'b1, 4'b0000, '0);
    for (int i = 1; i <= 5; i++) begin
      d = '0; d[1*W +: W] = 8'(i);
      step(1'b0, 4'b0010, d);
      if (i <= MAX_HOLD) chk("stream_q", 32'(q), 32'(i));
    end
    chk("stream_last_q", 32'(q), 32'h04);
    chk("stream_forced", 32'(forced), 32'h1);

    // reset in the second cycle of ownership
    step(1'b1, 4'b0000, '0);
    step(1'b0, 4'b1000, {N{8'h77}});
    step(1'b1, 4'b1000, {N{8'h77}});
    chk("midrst_grant", 32'(grant), 32'h0);
    chk("midrst_q", 32'(q), 32'h0);
    chk("midrst_ptr", 32'(ptr_dbg), 32'h0);

    // contention with ptr at 3
    step(1'b0, 4'b0100, {N{8'h11}});
    step(1'b0, 4'b0000, {N{8'h11}});
    chk("cont_ptr", 32'(ptr_dbg), 32'h3);
    step(1'b0, 4'b1001, {N{8'h22}});
    chk("cont_first", 32'(grant), 32'h8);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b1001, {N{8'h33}});
    chk("cont_gap", 32'(grant), 32'h0);
    step(1'b0, 4'b1001, {N{8'h44}});
    chk("cont_second", 32'(grant), 32'h1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), 4'($urandom), 32'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
